div_bus_master: RTL and testbench

- Synthesizable bus initiator for the calculator's divider peripheral; it plays the host side of the cs/rd/wr/addr peripheral bus.
- Accepts a dividend/divisor pair on a start handshake and performs the full transaction sequence: write DV, write DR, write START=1, poll DONE, clear START, read the result.
- Returns the quotient to the calculator datapath with a one-cycle done pulse, plus divide-by-zero and timeout flags.

---
 rtl/div_bus_master_if.sv | 20 ++
 rtl/div_bus_master.sv | 202 ++++++++++++++++++++
 tb/tb_div_bus_master.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_bus_master_if.sv
// Peripheral bus between the divider bus master and the divider register block.
// Read data returns in the cycle after the read strobe.
interface div_bus_master_if;
  logic        bus_cs;
  logic        bus_rd;
  logic        bus_wr;
  logic [4:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;

  modport master (
    output bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_cs, bus_rd, bus_wr, bus_addr, bus_wdata,
    output bus_rdata
  );
endinterface

// File: rtl/div_bus_master.sv
// Host-side sequencer for the divider peripheral: load operands, start, poll
// DONE, clear START, read the quotient. Every output is a flop.
//
//   state    | meaning
//   IDLE     | waiting for start
//   DIV0     | divisor was zero, report 0xFFFF with err_div0
//   WR_DV    | write dividend
//   WR_DR    | write divisor
//   WR_ST    | write START=1, restart poll count
//   RD_ST    | status read strobe
//   RD_ST_W  | status data returns, decide
//   WR_CLR   | write START=0
//   RD_RES   | result read strobe
//   RD_RES_W | result data returns
//   FIN      | done pulse
//   TOUT     | write START=0 and report timeout
module div_bus_master #(
  parameter logic [4:0] ADDR_DV    = 5'h04,
  parameter logic [4:0] ADDR_DR    = 5'h08,
  parameter logic [4:0] ADDR_START = 5'h0C,
  parameter logic [4:0] ADDR_RES   = 5'h10,
  parameter logic [4:0] ADDR_STAT  = 5'h14,
  parameter int         MAX_POLL   = 200
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              dividend,
  input  logic [15:0]              divisor,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              quotient,
  output logic                     err_div0,
  output logic                     timeout,
  div_bus_master_if.master         bus
);

  localparam int PW = $clog2(MAX_POLL + 1);

  typedef enum logic [3:0] {
    IDLE, DIV0, WR_DV, WR_DR, WR_ST, RD_ST, RD_ST_W,
    WR_CLR, RD_RES, RD_RES_W, FIN, TOUT
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [15:0]   dividend_q, dividend_d;
  logic [15:0]   divisor_q, divisor_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [15:0]   quotient_q, quotient_d;
  logic          err_div0_q, err_div0_d;
  logic          timeout_q, timeout_d;
  logic          bus_cs_q, bus_cs_d;
  logic          bus_rd_q, bus_rd_d;
  logic          bus_wr_q, bus_wr_d;
  logic [4:0]    bus_addr_q, bus_addr_d;
  logic [15:0]   bus_wdata_q, bus_wdata_d;

  always_comb begin
    state_d    = state_q;
    poll_d     = poll_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quotient_d = quotient_q;
    err_div0_d = err_div0_q;
    timeout_d  = timeout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          err_div0_d = 1'b0;
          timeout_d  = 1'b0;
          state_d    = (divisor == 16'd0) ? DIV0 : WR_DV;
        end
      end
      DIV0:    state_d = IDLE;
      WR_DV:   state_d = WR_DR;
      WR_DR:   state_d = WR_ST;
      WR_ST: begin
        poll_d  = '0;
        state_d = RD_ST;
      end
      RD_ST: begin
        poll_d  = poll_q + 1'b1;
        state_d = RD_ST_W;
      end
      RD_ST_W: begin
        if (bus.bus_rdata[0])              state_d = WR_CLR;
        else if (poll_q == PW'(MAX_POLL))  state_d = TOUT;
        else                               state_d = RD_ST;
      end
      WR_CLR:  state_d = RD_RES;
      RD_RES:  state_d = RD_RES_W;
      RD_RES_W: begin
        quotient_d = bus.bus_rdata;
        state_d    = FIN;
      end
      FIN:     state_d = IDLE;
      TOUT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they line up with it once registered.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DIV0) || (state_d == FIN) || (state_d == TOUT);
    bus_cs_d    = 1'b0;
    bus_rd_d    = 1'b0;
    bus_wr_d    = 1'b0;
    bus_addr_d  = 5'h00;
    bus_wdata_d = 16'h0000;

    case (state_d)
      DIV0: begin
        quotient_d = 16'hFFFF;
        err_div0_d = 1'b1;
      end
      WR_DV: begin
        {bus_cs_d, bus_wr_d} = 2'b11;
        bus_addr_d  = ADDR_DV;
        bus_wdata_d = dividend_d;
      end
      WR_DR: begin
        {bus_cs_d, bus_wr_d} = 2'b11;
        bus_addr_d  = ADDR_DR;
        bus_wdata_d = divisor_d;
      end
      WR_ST: begin
        {bus_cs_d, bus_wr_d} = 2'b11;
        bus_addr_d  = ADDR_START;
        bus_wdata_d = 16'd1;
      end
      RD_ST: begin
        {bus_cs_d, bus_rd_d} = 2'b11;
        bus_addr_d = ADDR_STAT;
      end
      WR_CLR: begin
        {bus_cs_d, bus_wr_d} = 2'b11;
        bus_addr_d = ADDR_START;
      end
      RD_RES: begin
        {bus_cs_d, bus_rd_d} = 2'b11;
        bus_addr_d = ADDR_RES;
      end
      TOUT: begin
        {bus_cs_d, bus_wr_d} = 2'b11;
        bus_addr_d = ADDR_START;
        quotient_d = 16'h0000;
        timeout_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      poll_q      <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      err_div0_q  <= 1'b0;
      timeout_q   <= 1'b0;
      bus_cs_q    <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      poll_q      <= poll_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      err_div0_q  <= err_div0_d;
      timeout_q   <= timeout_d;
      bus_cs_q    <= bus_cs_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign quotient      = quotient_q;
  assign err_div0      = err_div0_q;
  assign timeout       = timeout_q;
  assign bus.bus_cs    = bus_cs_q;
  assign bus.bus_rd    = bus_rd_q;
  assign bus.bus_wr    = bus_wr_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_div_bus_master.sv
// Directed bench for div_bus_master with a behavioural divider peripheral
// that raises DONE a fixed number of cycles after START=1.
module tb_div_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic        err_div0;
  logic        timeout;

  div_bus_master_if bus_if ();

  div_bus_master dut (
    .CLK      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .err_div0 (err_div0),
    .timeout  (timeout),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  // Peripheral model and bus monitors
  logic [15:0] r_dv = '0, r_dr = '0, r_res = '0;
  logic        run = 1'b0;
  int          lat = 0;
  logic        never_done = 1'b0;
  logic [20:0] wlog[$];
  int          st_reads = 0, res_reads = 0, cs_cnt = 0;
  int          both_hi = 0, rule_viol = 0;

  initial bus_if.bus_rdata = '0;

  always @(posedge clk) begin
    if (bus_if.bus_cs && bus_if.bus_wr) begin
      wlog.push_back({bus_if.bus_addr, bus_if.bus_wdata});
      case (bus_if.bus_addr)
        5'h04: r_dv <= bus_if.bus_wdata;
        5'h08: r_dr <= bus_if.bus_wdata;
        5'h0C: begin
          if (bus_if.bus_wdata[0]) begin
            run   <= 1'b1;
            lat   <= 20;
            r_res <= (r_dr != 0) ? r_dv / r_dr : 16'hFFFF;
          end else begin
            run <= 1'b0;
          end
        end
        default: ;
      endcase
    end else if (run && lat != 0) begin
      lat <= lat - 1;
    end

    if (bus_if.bus_cs && bus_if.bus_rd) begin
      if (bus_if.bus_addr == 5'h14) begin
        st_reads <= st_reads + 1;
        bus_if.bus_rdata <= {15'd0, run && (lat == 0) && !never_done};
      end else if (bus_if.bus_addr == 5'h10) begin
        res_reads <= res_reads + 1;
        bus_if.bus_rdata <= r_res;
      end else begin
        bus_if.bus_rdata <= 16'h0000;
      end
    end else begin
      bus_if.bus_rdata <= 16'h0000;
    end

    if (bus_if.bus_cs) cs_cnt <= cs_cnt + 1;
    if (bus_if.bus_rd && bus_if.bus_wr) both_hi <= both_hi + 1;
    if (bus_if.bus_cs && !(bus_if.bus_rd ^ bus_if.bus_wr)) rule_viol <= rule_viol + 1;
    if (!bus_if.bus_cs && (bus_if.bus_rd || bus_if.bus_wr || bus_if.bus_addr != 0 || bus_if.bus_wdata != 0))
      rule_viol <= rule_viol + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a sample point; returns at the sample point of cycle 1 after acceptance.
  task automatic start_op(input logic [15:0] dv, input logic [15:0] dr);
    start    = 1'b1;
    dividend = dv;
    divisor  = dr;
    tick();
    start = 1'b0;
  endtask

  // Waits for done; cyc is the cycle number (acceptance edge = 0) in which done is seen.
  task automatic wait_done(input int limit, input int inject, output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < limit) begin
      if (cyc == inject) begin
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 16'd3;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    if (done !== 1'b1) check("done_within_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_quot"},  {16'd0, quotient}, 32'd0);
    check({tag, "_div0"},  {31'd0, err_div0}, 32'd0);
    check({tag, "_tout"},  {31'd0, timeout}, 32'd0);
    check({tag, "_bus"},   {bus_if.bus_cs, bus_if.bus_rd, bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata}, 32'd0);
  endtask

  int cyc, w0, s0, r0, c0;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Nominal 900/5
    w0 = wlog.size(); s0 = st_reads; r0 = res_reads;
    start_op(16'd900, 16'd5);
    check("nom_c1_bus", {bus_if.bus_cs, bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata}, {2'b11, 5'h04, 16'd900});
    check("nom_c1_busy", {31'd0, busy}, 32'd1);
    wait_done(100, 0, cyc);
    check("nom_cycle", cyc, 29);
    check("nom_quot", {16'd0, quotient}, 32'd180);
    check("nom_flags", {err_div0, timeout, busy}, 3'b001);
    check("nom_polls", st_reads - s0, 11);
    check("nom_res_reads", res_reads - r0, 1);
    tick();
    check("nom_pulse", {done, busy}, 2'b00);
    check("nom_held", {16'd0, quotient}, 32'd180);
    check("nom_nwr", wlog.size() - w0, 4);
    check("nom_wr0", wlog[w0],     {5'h04, 16'd900});
    check("nom_wr1", wlog[w0 + 1], {5'h08, 16'd5});
    check("nom_wr2", wlog[w0 + 2], {5'h0C, 16'd1});
    check("nom_wr3", wlog[w0 + 3], {5'h0C, 16'd0});

    // Divide by zero
    c0 = cs_cnt;
    start_op(16'd7, 16'd0);
    wait_done(10, 0, cyc);
    check("div0_cycle", cyc, 1);
    check("div0_quot", {16'd0, quotient}, 32'hFFFF);
    check("div0_flags", {err_div0, timeout, busy}, 3'b101);
    tick();
    check("div0_pulse", {done, busy}, 2'b00);
    check("div0_no_cs", cs_cnt - c0, 0);

    // Timeout
    never_done = 1'b1;
    w0 = wlog.size(); s0 = st_reads; r0 = res_reads;
    start_op(16'd900, 16'd5);
    wait_done(1000, 0, cyc);
    check("tout_cycle", cyc, 404);
    check("tout_flags", {err_div0, timeout}, 2'b01);
    check("tout_quot", {16'd0, quotient}, 32'd0);
    check("tout_bus", {bus_if.bus_cs, bus_if.bus_wr, bus_if.bus_addr, bus_if.bus_wdata}, {2'b11, 5'h0C, 16'd0});
    check("tout_polls", st_reads - s0, 200);
    check("tout_res_reads", res_reads - r0, 0);
    tick();
    check("tout_pulse", {done, busy}, 2'b00);
    check("tout_nwr", wlog.size() - w0, 4);
    check("tout_lastwr", wlog[wlog.size() - 1], {5'h0C, 16'd0});
    never_done = 1'b0;

    // Start while busy is ignored
    w0 = wlog.size();
    start_op(16'd900, 16'd5);
    wait_done(100, 6, cyc);
    check("busy_start_cycle", cyc, 29);
    check("busy_start_quot", {16'd0, quotient}, 32'd180);
    tick();
    check("busy_start_nwr", wlog.size() - w0, 4);
    check("busy_start_wr0", wlog[w0],     {5'h04, 16'd900});
    check("busy_start_wr1", wlog[w0 + 1], {5'h08, 16'd5});

    // Reset during the first status wait cycle
    start_op(16'd900, 16'd5);
    repeat (4) tick();
    check("midpoll_state", {busy, bus_if.bus_cs, bus_if.bus_rd}, 3'b100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midpoll_rst");
    start_op(16'd10, 16'd3);
    wait_done(100, 0, cyc);
    check("after_rst_cycle", cyc, 29);
    check("after_rst_quot", {16'd0, quotient}, 32'd3);
    tick();

    // Back-to-back
    start_op(16'd65535, 16'd1);
    wait_done(100, 0, cyc);
    check("b2b1_quot", {16'd0, quotient}, 32'hFFFF);
    tick();
    check("b2b_gap", {done, busy}, 2'b00);
    check("b2b_gap_quot", {16'd0, quotient}, 32'hFFFF);
    start_op(16'd7, 16'd3);
    check("b2b2_accept", {31'd0, busy}, 32'd1);
    wait_done(100, 0, cyc);
    check("b2b2_cycle", cyc, 29);
    check("b2b2_quot", {16'd0, quotient}, 32'd2);
    tick();

    check("rd_wr_overlap", both_hi, 0);
    check("bus_rule_viol", rule_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
